// File: rtl/time_display_scanner.sv
// Converts binary MM:SS from the upstream counter to BCD with a sequential
// double-dabble engine and scans the four digits onto a shared 7-segment bus.
module time_display_scanner #(
  parameter int SCAN_DIV = 4,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  second,
  input  logic [5:0]  minute,
  output logic [15:0] bcd_time,
  output logic        bcd_valid,
  output logic [3:0]  digit_sel,
  output logic [6:0]  seg
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t      state, state_nxt;
  logic [5:0]  sec_cap, min_cap;
  logic [13:0] sec_sr, min_sr, sec_step, min_step;
  logic [2:0]  iter;
  logic        capture, commit;

  logic [DW-1:0] div;
  logic [1:0]    idx, next_idx;
  logic          wrap;
  logic [3:0]    digit;
  logic [6:0]    seg_nxt;

  // Shift register layout is {tens, ones, binary}; after six steps the
  // BCD pair sits in bits [13:6].
  function automatic logic [13:0] dabble_step(input logic [13:0] s);
    logic [13:0] t;
    t = s;
    if (t[13:10] >= 4'd5) t[13:10] = t[13:10] + 4'd3;
    if (t[9:6] >= 4'd5) t[9:6] = t[9:6] + 4'd3;
    return {t[12:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0: seg_enc = 7'h3F;
      4'd1: seg_enc = 7'h06;
      4'd2: seg_enc = 7'h5B;
      4'd3: seg_enc = 7'h4F;
      4'd4: seg_enc = 7'h66;
      4'd5: seg_enc = 7'h6D;
      4'd6: seg_enc = 7'h7D;
      4'd7: seg_enc = 7'h07;
      4'd8: seg_enc = 7'h7F;
      4'd9: seg_enc = 7'h6F;
      default: seg_enc = 7'h00;
    endcase
  endfunction

  assign sec_step = dabble_step(sec_sr);
  assign min_step = dabble_step(min_sr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (second != sec_cap || minute != min_cap) begin
          capture   = 1'b1;
          state_nxt = CONV;
        end
      end
      CONV: begin
        if (iter == 3'd5) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_cap   <= '0;
      min_cap   <= '0;
      sec_sr    <= '0;
      min_sr    <= '0;
      iter      <= '0;
      bcd_time  <= '0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= commit;
      if (capture) begin
        sec_cap <= second;
        min_cap <= minute;
        sec_sr  <= {8'd0, second};
        min_sr  <= {8'd0, minute};
        iter    <= '0;
      end else if (state == CONV) begin
        sec_sr <= sec_step;
        min_sr <= min_step;
        iter   <= iter + 3'd1;
      end
      if (commit) bcd_time <= {min_step[13:6], sec_step[13:6]};
    end
  end

  assign wrap     = (div == DIV_MAX);
  assign next_idx = wrap ? idx + 2'd1 : idx;

  always_comb begin
    digit = bcd_time[3:0];
    case (next_idx)
      2'd0: digit = bcd_time[3:0];
      2'd1: digit = bcd_time[7:4];
      2'd2: digit = bcd_time[11:8];
      2'd3: digit = bcd_time[15:12];
      default: digit = bcd_time[3:0];
    endcase
    seg_nxt = seg_enc(digit);
    if (BLANK_LZ && next_idx == 2'd3 && digit == 4'd0) seg_nxt = 7'h00;
  end

  // Select and segment data are registered together so they never skew.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div       <= '0;
      idx       <= '0;
      digit_sel <= 4'b0001;
      seg       <= 7'h3F;
    end else begin
      div       <= wrap ? '0 : div + DW'(1);
      idx       <= next_idx;
      digit_sel <= 4'b0001 << next_idx;
      seg       <= seg_nxt;
    end
  end

endmodule
